// File: rtl/key_pkg.sv
// Shared constants and vector type for the key debouncer
// and the key PIO wrapper.
package key_pkg;

  localparam int KEY_WIDTH        = 14;
  localparam int KEY_TICK_DIV     = 50000;
  localparam int KEY_STABLE_TICKS = 20;
  localparam int KEY_CNT_W        = 5;
  localparam int KEY_LONG_TICKS   = 1000;

  typedef logic [KEY_WIDTH-1:0] key_vec_t;

endpackage

// File: rtl/key_tick_gen.sv
// Free-running sample-tick prescaler shared by all key channels.
// tick is high for one cycle every TICK_DIV clocks.
module key_tick_gen
  import key_pkg::*;
#(
  parameter int TICK_DIV = KEY_TICK_DIV
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/key_debounce.sv
// Multi-channel key synchroniser/debouncer with press/release pulses.
// Optional long-press detect: define KEY_DEBOUNCE_LONG_PRESS_EN.
module key_debounce
  import key_pkg::*;
#(
  parameter int WIDTH        = KEY_WIDTH,
  parameter int TICK_DIV     = KEY_TICK_DIV,
  parameter int STABLE_TICKS = KEY_STABLE_TICKS,
  parameter int CNT_W        = KEY_CNT_W,
  parameter int ACTIVE_LOW   = 1,
  parameter int LONG_TICKS   = KEY_LONG_TICKS
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] keys_raw,
  output logic [WIDTH-1:0] key_level,
  output logic [WIDTH-1:0] key_press,
  output logic [WIDTH-1:0] key_release,
  output logic [WIDTH-1:0] key_long
);

  localparam logic [WIDTH-1:0] IDLE =
    (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(STABLE_TICKS - 1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] s;
  logic             tick;

  always_comb begin
    sync1_d = keys_raw;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= IDLE;
      sync2_q <= IDLE;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // s = 1 means pressed regardless of pin polarity
  assign s = sync2_q ^ IDLE;

  key_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic lvl_q, lvl_d;
    logic prs_q, prs_d;
    logic rel_q, rel_d;
    logic upd;

    // any agreeing sample aborts a pending change
    always_comb begin
      cnt_d = cnt_q;
      lvl_d = lvl_q;
      upd   = 1'b0;
      if (s[i] == lvl_q) begin
        cnt_d = '0;
      end else if (tick) begin
        if (cnt_q == LAST) begin
          lvl_d = s[i];
          cnt_d = '0;
          upd   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      prs_d = upd & s[i];
      rel_d = upd & ~s[i];
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
        lvl_q <= 1'b0;
        prs_q <= 1'b0;
        rel_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        lvl_q <= lvl_d;
        prs_q <= prs_d;
        rel_q <= rel_d;
      end
    end

    assign key_level[i]   = lvl_q;
    assign key_press[i]   = prs_q;
    assign key_release[i] = rel_q;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    localparam int HW = $clog2(LONG_TICKS + 1);
    localparam logic [HW-1:0] HMAX = HW'(LONG_TICKS);

    logic [HW-1:0] hold_q, hold_d;

    always_comb begin
      hold_d = hold_q;
      if (!lvl_q)
        hold_d = '0;
      else if (tick && hold_q != HMAX)
        hold_d = hold_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) hold_q <= '0;
      else          hold_q <= hold_d;
    end

    // gated by lvl_q so it drops on the same edge as the level
    assign key_long[i] = lvl_q & (hold_q == HMAX);
`else
    assign key_long[i] = 1'b0;
`endif
  end

endmodule
